// File: rtl/aes128_decrypt.sv
// Iterative AES-128 inverse cipher: one round per clock, valid/ready handshakes on both sides.
// The key schedule is expanded combinationally from the held key and indexed by the round count.
module aes128_decrypt (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);

  typedef enum logic [2:0] {StIdle, StInit, StRound, StFinal, StDone} state_e;

  state_e       state_q;
  logic [127:0] data_q;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic         out_valid_q;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (254 = 8'b1111_1110); maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [7:0] sub_bytes(input logic [7:0] x, input logic inverse);
    logic [7:0] v;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
    logic [7:0] r4;
    logic [7:0] r6;
    if (inverse) begin
      r1 = rotl1(x);
      r2 = rotl1(r1);
      r3 = rotl1(r2);
      r4 = rotl1(r3);
      r6 = rotl1(rotl1(r4));
      return gf_inv(r1 ^ r3 ^ r6 ^ 8'h05);
    end
    v  = gf_inv(x);
    r1 = rotl1(v);
    r2 = rotl1(r1);
    r3 = rotl1(r2);
    r4 = rotl1(r3);
    return v ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] d);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = d[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] d);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8 * i -: 8] = sub_bytes(d[127 - 8 * i -: 8], 1'b1);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] d);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = d[127 - 32 * c -: 8];
      a1 = d[119 - 32 * c -: 8];
      a2 = d[111 - 32 * c -: 8];
      a3 = d[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^
                             gf_mul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^
                             gf_mul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^
                             gf_mul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^
                             gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] d, input logic [127:0] k);
    return d ^ k;
  endfunction

  function automatic logic [127:0] key_expansion(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    int          ri;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {sub_bytes(t[23:16], 1'b0), sub_bytes(t[15:8], 1'b0), sub_bytes(t[7:0], 1'b0),
             sub_bytes(t[31:24], 1'b0)} ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    ri = (r > 4'd10) ? 10 : int'(r);
    return {w[4 * ri], w[4 * ri + 1], w[4 * ri + 2], w[4 * ri + 3]};
  endfunction

  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] final_out;
  logic [127:0] round_out;

  always_comb begin
    rk_idx = 4'd0;
    case (state_q)
      StInit:  rk_idx = 4'd10;
      StRound: rk_idx = round_q;
      default: rk_idx = 4'd0;
    endcase
    rk        = key_expansion(key_q, rk_idx);
    final_out = add_round_key(inv_sub_bytes(inv_shift_rows(data_q)), rk);
    round_out = inv_mix_columns(final_out);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      data_q      <= '0;
      key_q       <= '0;
      round_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            data_q  <= ct;
            key_q   <= key;
            state_q <= StInit;
          end
        end
        StInit: begin
          data_q  <= add_round_key(data_q, rk);
          round_q <= 4'd9;
          state_q <= StRound;
        end
        StRound: begin
          data_q <= round_out;
          if (round_q == 4'd1) state_q <= StFinal;
          else                 round_q <= round_q - 4'd1;
        end
        StFinal: begin
          data_q      <= final_out;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q inside {StInit, StRound, StFinal, StDone});
  assign out_valid = out_valid_q;
  assign pt        = data_q;

endmodule

// File: tb/tb_aes128_decrypt.sv
// Directed-vector bench for aes128_decrypt: FIPS-197 vectors, stalls, ignored input, reset.
module tb_aes128_decrypt;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] ct = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] pt;
  logic         busy;

  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PtZ   = 128'h140f0f1011b5223d79587717ffd9ec3a;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  aes128_decrypt dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag, input logic [127:0] c, input logic [127:0] k);
    ct       = c;
    key      = k;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int           n;
    int           acc0;
    int           acc1;
    int           ok1;
    int           ok2;
    int           nout;
    logic         pre;
    logic [127:0] o1;
    logic [127:0] o2;

    #2 rst = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_pt", pt, 128'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // FIPS-197 C.1, consumer always ready
    out_ready = 1'b1;
    accept("c1", CtC1, KeyC1);
    check("c1_busy", 128'(busy), 128'd1);
    wait_out(n);
    check("c1_latency", 128'(n), 128'd11);
    check("c1_pt", pt, PtC1);
    tick();
    check("c1_one_cycle", 128'(out_valid), 128'd0);
    check("c1_idle", 128'(in_ready), 128'd1);

    // FIPS-197 B, consumer stalls for 5 cycles; inputs scrambled after acceptance
    out_ready = 1'b0;
    accept("b", CtB, KeyB);
    ct  = ~CtB;
    key = ~KeyB;
    wait_out(n);
    check("b_latency", 128'(n), 128'd11);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_stall_valid", 128'(out_valid), 128'd1);
      check("b_stall_pt", pt, PtB);
      check("b_stall_in_ready", 128'(in_ready), 128'd0);
      check("b_stall_busy", 128'(busy), 128'd1);
    end
    out_ready = 1'b1;
    tick();
    check("b_taken_valid", 128'(out_valid), 128'd0);
    check("b_taken_ready", 128'(in_ready), 128'd1);

    // Ignored input while busy; all-zero pair must only be taken at E13
    accept("ign", CtC1, KeyC1);
    in_valid = 1'b1;
    acc1 = -1;
    ok1  = -1;
    o1   = '0;
    for (int k = 1; k <= 14; k++) begin
      if (k < 13) begin
        ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        ct  = '0;
        key = '0;
      end
      pre = in_ready && in_valid;
      tick();
      if (out_valid) begin
        o1  = pt;
        ok1 = k;
      end
      if (pre) begin
        acc1     = k;
        in_valid = 1'b0;
        break;
      end
    end
    check("ign_accept_edge", 128'(acc1), 128'd13);
    check("ign_out_edge", 128'(ok1), 128'd11);
    check("ign_pt", o1, PtC1);
    wait_out(n);
    check("zero_latency", 128'(n), 128'd11);
    check("zero_pt", pt, PtZ);
    tick();

    // Back-to-back C.1 then B with in_valid and out_ready held high
    ct       = CtC1;
    key      = KeyC1;
    in_valid = 1'b1;
    acc0 = -1;
    acc1 = -1;
    ok1  = -1;
    ok2  = -1;
    nout = 0;
    o1   = '0;
    o2   = '0;
    for (int k = 0; k < 30; k++) begin
      pre = in_ready && in_valid;
      tick();
      if (pre) begin
        if (acc0 < 0) begin
          acc0 = k;
          ct   = CtB;
          key  = KeyB;
        end else begin
          acc1     = k;
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (nout == 0) begin
          o1  = pt;
          ok1 = k;
        end else if (nout == 1) begin
          o2  = pt;
          ok2 = k;
        end
        nout++;
      end
    end
    in_valid = 1'b0;
    check("b2b_spacing", 128'(acc1 - acc0), 128'd13);
    check("b2b_lat1", 128'(ok1 - acc0), 128'd11);
    check("b2b_lat2", 128'(ok2 - acc1), 128'd11);
    check("b2b_pt1", o1, PtC1);
    check("b2b_pt2", o2, PtB);
    check("b2b_count", 128'(nout), 128'd2);

    // Reset mid-round, then a clean decrypt
    accept("mid", CtC1, KeyC1);
    for (int i = 0; i < 5; i++) tick();
    check("mid_busy_before", 128'(busy), 128'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_pt", pt, 128'd0);
    check("mid_rst_ready", 128'(in_ready), 128'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_post_valid", 128'(out_valid), 128'd0);
    check("mid_post_pt", pt, 128'd0);
    accept("mid_c1", CtC1, KeyC1);
    wait_out(n);
    check("mid_c1_latency", 128'(n), 128'd11);
    check("mid_c1_pt", pt, PtC1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
